// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer for a synchronous-read instruction ROM with a two-entry output buffer.
// Define FETCH_ALIGN_CHECK_EN to flag and block fetch on misaligned redirect targets.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    logic [31:0] pc;
    logic        iss_q;
    logic [31:0] iss_pc_q;
    logic        out_v;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        sk_v;
    logic [31:0] sk_inst;
    logic [31:0] sk_pc;

    logic [31:0] pc_d;
    logic        iss_q_d;
    logic [31:0] iss_pc_d;
    logic        out_v_d;
    logic [31:0] out_inst_d;
    logic [31:0] out_pc_d;
    logic        sk_v_d;
    logic [31:0] sk_inst_d;
    logic [31:0] sk_pc_d;

    logic        pop;
    logic        issue;
    logic        fault_block;
    logic [1:0]  occ;
    logic [1:0]  occ_left;
    logic [31:0] redir_target;

    assign rom_addr   = pc;
    assign inst_valid = out_v;
    assign inst_out   = out_inst;
    assign inst_pc    = out_pc;

    assign pop      = out_v & inst_ready;
    assign occ      = 2'(out_v) + 2'(sk_v) + 2'(iss_q);
    assign occ_left = occ - 2'(pop);
    // Only issue when the response already in flight plus this one still fit in two entries.
    assign issue    = fetch_en & ~fault_block & ~redirect_valid & (occ_left < 2'd2);

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= |redirect_pc[1:0];
        end
    end

    assign fault_block  = fault_q;
    assign fetch_fault  = fault_q;
    assign redir_target = redirect_pc;
`else
    logic unused_lsb;

    assign unused_lsb   = ^redirect_pc[1:0];
    assign fault_block  = 1'b0;
    assign fetch_fault  = 1'b0;
    assign redir_target = {redirect_pc[31:2], 2'b00};
`endif

    always_comb begin
        pc_d       = pc;
        iss_q_d    = issue;
        iss_pc_d   = iss_pc_q;
        out_v_d    = out_v;
        out_inst_d = out_inst;
        out_pc_d   = out_pc;
        sk_v_d     = sk_v;
        sk_inst_d  = sk_inst;
        sk_pc_d    = sk_pc;

        if (issue) begin
            pc_d     = pc + 32'd4;
            iss_pc_d = pc;
        end

        // The skid is only ever occupied behind a valid output entry, so order is oldest-first:
        // output, skid, then the response arriving on rom_data.
        if (pop) begin
            if (sk_v) begin
                out_inst_d = sk_inst;
                out_pc_d   = sk_pc;
                sk_v_d     = iss_q;
                if (iss_q) begin
                    sk_inst_d = rom_data;
                    sk_pc_d   = iss_pc_q;
                end
            end else begin
                out_v_d = iss_q;
                if (iss_q) begin
                    out_inst_d = rom_data;
                    out_pc_d   = iss_pc_q;
                end
            end
        end else if (iss_q) begin
            if (!out_v) begin
                out_v_d    = 1'b1;
                out_inst_d = rom_data;
                out_pc_d   = iss_pc_q;
            end else begin
                sk_v_d    = 1'b1;
                sk_inst_d = rom_data;
                sk_pc_d   = iss_pc_q;
            end
        end

        if (redirect_valid) begin
            pc_d    = redir_target;
            out_v_d = 1'b0;
            sk_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            iss_q    <= 1'b0;
            iss_pc_q <= 32'h0;
            out_v    <= 1'b0;
            out_inst <= 32'h0;
            out_pc   <= 32'h0;
            sk_v     <= 1'b0;
            sk_inst  <= 32'h0;
            sk_pc    <= 32'h0;
        end else begin
            pc       <= pc_d;
            iss_q    <= iss_q_d;
            iss_pc_q <= iss_pc_d;
            out_v    <= out_v_d;
            out_inst <= out_inst_d;
            out_pc   <= out_pc_d;
            sk_v     <= sk_v_d;
            sk_inst  <= sk_inst_d;
            sk_pc    <= sk_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run scored against an in-order PC stream model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass = 0;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_out(inst_out),
        .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h00c20213;
            32'h0000_0018: rom_word = 32'h06520263;
            32'h0000_0080: rom_word = 32'h00002303;
            default:       rom_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Synchronous-read ROM: data for the sampled address appears after the edge.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        fetch_en = 1'b1;
        inst_ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_en = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (inst_out !== 32'h0) $display("FAIL reset_inst_out: got %h want 0", inst_out); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h want 0", inst_pc); else n_pass++;
        n_checks++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault); else n_pass++;
        n_checks++; if (rom_addr !== RESET_PC) $display("FAIL reset_rom_addr: got %h want %h", rom_addr, RESET_PC); else n_pass++;
        rst_n = 1'b1;
        cyc();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL first_edge_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (rom_addr !== RESET_PC + 32'd4) $display("FAIL first_edge_addr: got %h want %h", rom_addr, RESET_PC + 32'd4); else n_pass++;
        cyc();
        for (int i = 0; i < 7; i++) begin
            logic [31:0] ep;
            ep = RESET_PC + 32'(i * 4);
            n_checks++; if (inst_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", i, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== ep) $display("FAIL seq_pc[%0d]: got %h want %h", i, inst_pc, ep); else n_pass++;
            n_checks++; if (inst_out !== rom_word(ep)) $display("FAIL seq_inst[%0d]: got %h want %h", i, inst_out, rom_word(ep)); else n_pass++;
            if (i == 0) begin
                n_checks++; if (inst_out !== 32'h00c20213) $display("FAIL seq_first_word: got %h want 00c20213", inst_out); else n_pass++;
            end
            if (i == 6) begin
                n_checks++; if (inst_out !== 32'h06520263) $display("FAIL seq_word_18: got %h want 06520263", inst_out); else n_pass++;
            end
            cyc();
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        n_checks++; if (inst_pc !== 32'hC) $display("FAIL stall_start_pc: got %h want c", inst_pc); else n_pass++;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++; if (inst_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== 32'hC) $display("FAIL stall_pc[%0d]: got %h want c", i, inst_pc); else n_pass++;
            n_checks++; if (rom_addr !== 32'h14) $display("FAIL stall_rom_addr[%0d]: got %h want 14", i, rom_addr); else n_pass++;
        end
        inst_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            logic [31:0] ep;
            ep = 32'hC + 32'(i * 4);
            cyc();
            n_checks++; if (inst_valid !== 1'b1) $display("FAIL resume_valid[%0d]: got %b want 1", i, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== ep) $display("FAIL resume_pc[%0d]: got %h want %h", i, inst_pc, ep); else n_pass++;
        end
    endtask

    task automatic test_fetch_en();
        do_reset();
        cyc();
        cyc();
        fetch_en = 1'b0;
        cyc();
        n_checks++; if (inst_pc !== 32'h4 || inst_valid !== 1'b1) $display("FAIL drain_pc: got %h/%b want 4/1", inst_pc, inst_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (inst_valid !== 1'b0) $display("FAIL drain_empty[%0d]: got %b want 0", i, inst_valid); else n_pass++;
            n_checks++; if (rom_addr !== 32'h8) $display("FAIL drain_addr[%0d]: got %h want 8", i, rom_addr); else n_pass++;
        end
        fetch_en = 1'b1;
    endtask

    task automatic test_redirect_buffered();
        do_reset();
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        inst_ready = 1'b0;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        cyc();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rbuf_flush_r0: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (rom_addr !== 32'h80) $display("FAIL rbuf_rom_addr: got %h want 80", rom_addr); else n_pass++;
        cyc();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rbuf_flush_r1: got %b want 0", inst_valid); else n_pass++;
        cyc();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80) $display("FAIL rbuf_target_pc: got %h/%b want 80/1", inst_pc, inst_valid); else n_pass++;
        n_checks++; if (inst_out !== 32'h00002303) $display("FAIL rbuf_target_inst: got %h want 00002303", inst_out); else n_pass++;
        cyc();
        n_checks++; if (inst_pc !== 32'h84) $display("FAIL rbuf_next_pc: got %h want 84", inst_pc); else n_pass++;
    endtask

    task automatic test_redirect_pop();
        do_reset();
        cyc();
        cyc();
        cyc();
        n_checks++; if (inst_pc !== 32'h4) $display("FAIL rpop_pre_pc: got %h want 4", inst_pc); else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        inst_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rpop_r0: got %b want 0", inst_valid); else n_pass++;
        cyc();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rpop_r1: got %b want 0", inst_valid); else n_pass++;
        cyc();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) $display("FAIL rpop_target: got %h/%b want 40/1", inst_pc, inst_valid); else n_pass++;
        inst_ready = 1'b0;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'hC0;
        cyc();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rstall_r0: got %b want 0", inst_valid); else n_pass++;
        cyc();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rstall_r1: got %b want 0", inst_valid); else n_pass++;
        cyc();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC0) $display("FAIL rstall_target: got %h/%b want c0/1", inst_pc, inst_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc();
        cyc();
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0 || inst_out !== 32'h0) $display("FAIL areset_data: got %h/%h want 0/0", inst_pc, inst_out); else n_pass++;
        n_checks++; if (rom_addr !== RESET_PC) $display("FAIL areset_addr: got %h want %h", rom_addr, RESET_PC); else n_pass++;
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL areset_restart_e1: got %b want 0", inst_valid); else n_pass++;
        cyc();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) $display("FAIL areset_restart_pc: got %h/%b want %h/1", inst_pc, inst_valid, RESET_PC); else n_pass++;
    endtask

    task automatic test_align();
        do_reset();
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h82;
        cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (fetch_fault !== 1'b1) $display("FAIL align_fault[%0d]: got %b want 1", i, fetch_fault); else n_pass++;
            n_checks++; if (inst_valid !== 1'b0) $display("FAIL align_blocked[%0d]: got %b want 0", i, inst_valid); else n_pass++;
            n_checks++; if (rom_addr !== 32'h82) $display("FAIL align_addr[%0d]: got %h want 82", i, rom_addr); else n_pass++;
            cyc();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        cyc();
        redirect_valid = 1'b0;
        n_checks++; if (fetch_fault !== 1'b0) $display("FAIL align_clear: got %b want 0", fetch_fault); else n_pass++;
        cyc();
        cyc();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80) $display("FAIL align_resume_pc: got %h/%b want 80/1", inst_pc, inst_valid); else n_pass++;
        n_checks++; if (inst_out !== 32'h00002303) $display("FAIL align_resume_inst: got %h want 00002303", inst_out); else n_pass++;
`else
        n_checks++; if (fetch_fault !== 1'b0) $display("FAIL noalign_fault: got %b want 0", fetch_fault); else n_pass++;
        n_checks++; if (rom_addr !== 32'h80) $display("FAIL noalign_addr: got %h want 80", rom_addr); else n_pass++;
        cyc();
        cyc();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80) $display("FAIL noalign_pc: got %h/%b want 80/1", inst_pc, inst_valid); else n_pass++;
        n_checks++; if (inst_out !== 32'h00002303) $display("FAIL noalign_inst: got %h want 00002303", inst_out); else n_pass++;
`endif
    endtask

    // Reference: the delivered stream is RESET_PC or the last redirect target, counting up by 4,
    // each element handed over exactly once per handshake; redirects blank the output for two edges;
    // with fetch enabled and no redirect for two edges the output must hold something.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] r;
        logic [31:0] tgt;
        int          since_redir;
        int          n_pop;
        logic        prev_en, prev_nr, cur_en, cur_nr;
        do_reset();
        cyc();
        cyc();
        exp_pc = RESET_PC;
        since_redir = 10;
        n_pop = 0;
        cur_en = 1'b0;
        cur_nr = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (since_redir < 2) begin
                n_checks++; if (inst_valid !== 1'b0) $display("FAIL rnd_flush_gap[%0d]: got %b want 0", k, inst_valid); else n_pass++;
            end
            if (prev_en && prev_nr && cur_nr) begin
                n_checks++; if (inst_valid !== 1'b1) $display("FAIL rnd_live[%0d]: got %b want 1", k, inst_valid); else n_pass++;
            end
            if (inst_valid === 1'b1) begin
                n_checks++; if (inst_pc !== exp_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", k, inst_pc, exp_pc); else n_pass++;
                n_checks++; if (inst_out !== rom_word(exp_pc)) $display("FAIL rnd_inst[%0d]: got %h want %h", k, inst_out, rom_word(exp_pc)); else n_pass++;
            end
            inst_ready = ($urandom_range(0, 9) < 7);
            fetch_en = ($urandom_range(0, 7) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            r = $urandom;
            tgt = {r[31:2], 2'b00};
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0;
            redirect_pc = tgt;
            if (inst_valid === 1'b1 && inst_ready) begin
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
            if (redirect_valid) exp_pc = tgt;
            prev_en = cur_en;
            prev_nr = cur_nr;
            cur_en = fetch_en;
            cur_nr = !redirect_valid;
            cyc();
            if (redirect_valid) since_redir = 0;
            else if (since_redir < 10) since_redir++;
        end
        redirect_valid = 1'b0;
        n_checks++; if (n_pop < 500) $display("FAIL rnd_throughput: got %0d pops want >= 500", n_pop); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_fetch_en();
        test_redirect_buffered();
        test_redirect_pop();
        test_async_reset();
        test_align();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the address port of the instruction ROM (`ROM`, synchronous read, data valid one cycle after the address is sampled). It maintains the PC, issues word addresses, absorbs the one-cycle ROM latency with a two-entry output buffer, and presents instructions to decode over a valid/ready handshake. Decode or execute can redirect it on branches. It sits between `ROM` and the decode stage.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; release is synchronous to `clk`.
- `fetch_en`  in  1  high permits new address issue; low stops issue, in-flight data still completes.
- `redirect_valid`  in  1  one-cycle pulse: flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `rom_addr`  out  32  address to `ROM.Address`, driven directly from the PC register.
- `rom_data`  in  32  `ROM.InstOut`.
- `inst_valid`  out  1  `inst_out`/`inst_pc` hold a valid instruction.
- `inst_ready`  in  1  decode accepts the instruction when high with `inst_valid`.
- `inst_out`  out  32  instruction word.
- `inst_pc`  out  32  address of `inst_out`.
- `fetch_fault`  out  1  misaligned redirect flag; see Configuration.

## Operation
State:
- `pc`: next address to issue.
- `iss_q` and `iss_pc_q`: an address issued last cycle, so its data is on `rom_data` this cycle.
- Output entry: `out_v`, `out_inst`, `out_pc`.
- Skid entry: `sk_v`, `sk_inst`, `sk_pc`.

Rules:
- `rom_addr = pc` at all times.
- `pop = inst_valid & inst_ready`.
- `occ = out_v + sk_v + iss_q`.
- `issue = fetch_en & ~fault_block & (occ - pop < 2)`. When `issue` is high: `iss_q <= 1`, `iss_pc_q <= pc`, `pc <= pc + 4`. The add is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. Otherwise `iss_q <= 0` and `pc` holds.
- Response capture when `iss_q` is high:
  - If the output entry is free or popping this cycle and the skid is empty, capture into the output entry.
  - Otherwise capture into the skid entry.
- On `pop`: the skid entry moves to the output entry if `sk_v`; otherwise the output entry is loaded from the response or cleared.
- Order is always preserved, and an instruction is never dropped or duplicated.
- Redirect has priority over all other updates in the same cycle:
  - `out_v`, `sk_v` and `iss_q` are cleared, which drops the in-flight response.
  - `pc <= redirect_pc`.
  - No issue occurs that cycle.
  - A concurrent `pop` is still a legal handshake for the old instruction.
- Occupancy never exceeds 2, and the skid entry is only used while the output entry is stalled.

## Timing
- Reset values: `pc = RESET_PC`, `iss_q = 0`, `out_v = sk_v = 0`, `inst_valid = 0`, `inst_out = 0`, `inst_pc = 0`, `fetch_fault = 0`. `rom_addr` equals `RESET_PC` during reset.
- Issue latency: an address issued at edge E (`iss_q` set) is captured at E+1 and is visible as `inst_valid` after E+1.
- After reset release, the first issue is at the first edge; `inst_valid` rises after the second edge.
- Redirect at edge R: target issued at R+1, `inst_valid` with `inst_pc = redirect_pc` after R+2; `inst_valid` is low between R and R+2.
- Throughput is 1 instruction per cycle while `inst_ready` is held high.
- `inst_ready` low for N cycles: at most 2 instructions are buffered and issue halts. When `inst_ready` returns, delivery resumes the next cycle with no bubble for the 2 buffered entries.
- `fetch_en` deasserted: no new issue from the next edge; up to 2 buffered instructions still drain.
- `rst_n` asserted mid-operation immediately clears all state to reset values, without waiting for a clock edge.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes as normal, sets `fetch_fault` (sticky) and sets `fault_block`, so no issue occurs.
  - `pc` loads the raw target.
  - The next aligned redirect clears `fetch_fault` and resumes fetching; reset also clears it.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `pc` loads `{redirect_pc[31:2], 2'b00}`.
  - `fetch_fault` is tied to 0 and `fault_block` is tied to 0.

## Test plan
- Reset with `RESET_PC = 0`, `fetch_en = 1`, `inst_ready = 1` -> `inst_pc` sequence 0x0, 0x4, 0x8, 0xC, 0x10, 0x14, 0x18 on consecutive cycles; `inst_out` 0x00c20213 first and 0x06520263 at 0x18.
- `inst_ready` low for 5 cycles mid-stream -> `inst_valid` held with stable `inst_pc`, `rom_addr` frozen; on release the next 3 PCs arrive back-to-back with no gap or repeat.
- `redirect_valid` with `redirect_pc = 0x80` while 2 instructions are buffered -> both discarded; after 2 edges `inst_pc = 0x80` and `inst_out = 0x00002303`.
- Redirect in the same cycle as `pop`, and redirect while `inst_ready` is low -> the popped instruction counts once, and the next delivered `inst_pc` equals the target.
- `rst_n` pulsed low asynchronously mid-stream -> `inst_valid` drops immediately; the restart delivers `RESET_PC` after 2 edges.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x82 -> `fetch_fault = 1` and no `inst_valid`; then redirect to 0x80 -> `fetch_fault = 0` and 0x00002303 is delivered. Without the macro, redirect to 0x82 delivers `inst_pc = 0x80`.
